// File: rtl/rope_electro_ctrl_pkg.sv
// Shared types for the rope electrification scheduler: rope FSM states, status encodings, LFSR step.
// Optional WARN phase is controlled by the ROPE_ELECTRO_WARN_EN macro in the cell.
package electro_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      WARN = 2'd1,
      LIVE = 2'd2,
      COOL = 2'd3
   } rope_state_t;

   localparam logic [1:0] E_OFF  = 2'b00;
   localparam logic [1:0] E_WARN = 2'b01;
   localparam logic [1:0] E_LIVE = 2'b10;

   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rope_electro_ctrl_if.sv
// Frame/enable inputs and per-rope status outputs of the rope electrification scheduler.
interface rope_electro_if #(
   parameter int ROPES = 6
) ();
   logic                  startOfFrame;
   logic                  enable;
   logic [ROPES-1:0][1:0] electroStatus;
   logic [3:0]            activeCount;

   modport master (
      output startOfFrame,
      output enable,
      input  electroStatus,
      input  activeCount
   );

   modport slave (
      input  startOfFrame,
      input  enable,
      output electroStatus,
      output activeCount
   );
endinterface

// File: rtl/rope_electro_ctrl_cell.sv
// One rope: OFF -> WARN -> LIVE -> COOL -> OFF, each phase lasting its parameter in frames.
// Without ROPE_ELECTRO_WARN_EN a spawn goes straight from OFF to LIVE.
module rope_electro_cell
   import electro_pkg::*;
#(
   parameter int WARN_FRAMES = 30,
   parameter int LIVE_FRAMES = 60,
   parameter int COOL_FRAMES = 45
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        clear,
   input  logic        spawn,
   output rope_state_t state,
   output logic [1:0]  status,
   output logic        active_next
);
   localparam int MAXD_A = (WARN_FRAMES > LIVE_FRAMES) ? WARN_FRAMES : LIVE_FRAMES;
   localparam int MAXD   = (MAXD_A > COOL_FRAMES) ? MAXD_A : COOL_FRAMES;
   localparam int CW     = (MAXD > 1) ? $clog2(MAXD) : 1;

   rope_state_t   state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_reg <= OFF;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Counter holds frames remaining minus one; a frame with counter zero takes the transition
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (clear) begin
         state_next = OFF;
         cnt_next   = '0;
      end else if (startOfFrame) begin
         case (state_reg)
            OFF: begin
               if (spawn) begin
`ifdef ROPE_ELECTRO_WARN_EN
                  state_next = WARN;
                  cnt_next   = CW'(WARN_FRAMES - 1);
`else
                  state_next = LIVE;
                  cnt_next   = CW'(LIVE_FRAMES - 1);
`endif
               end
            end
            WARN: begin
               if (cnt_reg != '0) begin
                  cnt_next = cnt_reg - CW'(1);
               end else begin
                  state_next = LIVE;
                  cnt_next   = CW'(LIVE_FRAMES - 1);
               end
            end
            LIVE: begin
               if (cnt_reg != '0) begin
                  cnt_next = cnt_reg - CW'(1);
               end else begin
                  state_next = COOL;
                  cnt_next   = CW'(COOL_FRAMES - 1);
               end
            end
            COOL: begin
               if (cnt_reg != '0) begin
                  cnt_next = cnt_reg - CW'(1);
               end else begin
                  state_next = OFF;
                  cnt_next   = '0;
               end
            end
            default: begin
               state_next = OFF;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_comb begin
      active_next = (state_next == WARN) || (state_next == LIVE);
      case (state_reg)
         WARN:    status = E_WARN;
         LIVE:    status = E_LIVE;
         default: status = E_OFF;
      endcase
   end

   assign state = state_reg;

endmodule

// File: rtl/rope_electro_ctrl.sv
// Rope electrification scheduler: frame-stepped LFSR picks a candidate rope, spawn timer paces attempts.
// ROPE_ELECTRO_WARN_EN enables the WARN (sparking) phase before LIVE.
module rope_electro_ctrl
   import electro_pkg::*;
#(
   parameter int         ROPES        = 6,
   parameter int         WARN_FRAMES  = 30,
   parameter int         LIVE_FRAMES  = 60,
   parameter int         COOL_FRAMES  = 45,
   parameter int         SPAWN_FRAMES = 90,
   parameter int         MAX_ACTIVE   = 2,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input  logic           clk,
   input  logic           resetN,
   rope_electro_if.slave  bus
);
   localparam int TW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

   logic [7:0]       lfsr_reg;
   logic [TW-1:0]    timer_reg, timer_next;
   logic [3:0]       count_reg, count_next;
   rope_state_t      rope_state  [ROPES];
   logic [1:0]       rope_status [ROPES];
   logic [ROPES-1:0] act_next;
   logic [ROPES-1:0] spawn_vec;
   logic [7:0]       cand_free;
   logic [2:0]       cand;
   logic             timer_sat;
   logic             spawn_ok;

   assign cand      = lfsr_reg[2:0];
   assign timer_sat = (timer_reg == TW'(SPAWN_FRAMES - 1));

   // Candidates 6/7 beyond ROPES stay 0 here, so those attempts simply fail
   always_comb begin
      cand_free = '0;
      for (int i = 0; i < ROPES; i++) begin
         cand_free[i] = (rope_state[i] == OFF);
      end
   end

   assign spawn_ok = bus.startOfFrame && bus.enable && timer_sat && cand_free[cand]
                     && (count_reg < 4'(MAX_ACTIVE));

   generate
      for (genvar gi = 0; gi < ROPES; gi++) begin : g_rope
         assign spawn_vec[gi] = spawn_ok && (cand == 3'(gi));

         rope_electro_cell #(
            .WARN_FRAMES (WARN_FRAMES),
            .LIVE_FRAMES (LIVE_FRAMES),
            .COOL_FRAMES (COOL_FRAMES)
         ) u_cell (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (bus.startOfFrame),
            .clear        (!bus.enable),
            .spawn        (spawn_vec[gi]),
            .state        (rope_state[gi]),
            .status       (rope_status[gi]),
            .active_next  (act_next[gi])
         );

         assign bus.electroStatus[gi] = rope_status[gi];
      end
   endgenerate

   always_comb begin
      timer_next = timer_reg;
      if (!bus.enable) begin
         timer_next = '0;
      end else if (bus.startOfFrame) begin
         if (spawn_ok) begin
            timer_next = '0;
         end else if (!timer_sat) begin
            timer_next = timer_reg + TW'(1);
         end
      end
   end

   always_comb begin
      count_next = '0;
      for (int i = 0; i < ROPES; i++) begin
         count_next = count_next + 4'(act_next[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         lfsr_reg  <= LFSR_SEED;
         timer_reg <= '0;
         count_reg <= '0;
      end else begin
         if (bus.startOfFrame) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
         end
         timer_reg <= timer_next;
         count_reg <= count_next;
      end
   end

   assign bus.activeCount = count_reg;

endmodule
